// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of the shared ROM+RAM memory controller.
// Optional build macro ARB_ROUND_ROBIN_EN replaces CPU priority + burst guard with strict alternation.
module mem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ROM_END   = 152099,
   parameter int RAM_END   = 305735,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wd,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rd,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [DATA_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wd,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rd,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   output logic              err,
   output logic [DATA_W-1:0] err_addr
);

   localparam logic [DATA_W-1:0] ROM_END_W = DATA_W'(ROM_END);
   localparam logic [DATA_W-1:0] RAM_END_W = DATA_W'(RAM_END);

   typedef enum logic [1:0] {WIN_NONE, WIN_CPU, WIN_DMA} win_e;

   win_e              win;
   logic              cpu_pref;
   logic              sel_we;
   logic [DATA_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wd;
   logic              illegal;

   logic              cpu_rvalid_q, dma_rvalid_q;
   logic [DATA_W-1:0] cpu_rd_q, dma_rd_q;
   logic              err_q;
   logic [DATA_W-1:0] err_addr_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_dma;

   // Under contention the requester that did not win last time goes next.
   assign cpu_pref = last_dma;
`else
   localparam logic [3:0] MAX_BURST_W = 4'(MAX_BURST);

   logic [3:0] burst_cnt;

   // CPU keeps priority until it has starved a waiting DMA for MAX_BURST grants.
   assign cpu_pref = (burst_cnt != MAX_BURST_W);
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      win      = WIN_NONE;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_wd   = '0;
      if (!reset) begin
         if (cpu_req && (!dma_req || cpu_pref)) begin
            win = WIN_CPU;
         end else if (dma_req) begin
            win = WIN_DMA;
         end
      end
      case (win)
         WIN_CPU: begin
            sel_we   = cpu_we;
            sel_addr = cpu_addr;
            sel_wd   = cpu_wd;
         end
         WIN_DMA: begin
            sel_we   = dma_we;
            sel_addr = dma_addr;
            sel_wd   = dma_wd;
         end
         default: ;
      endcase
   end

   assign illegal  = (win != WIN_NONE) &&
                     ((sel_we && (sel_addr <= ROM_END_W)) || (sel_addr > RAM_END_W));

   // Illegal accesses are still granted but never reach the memory.
   assign mem_we   = sel_we && !illegal;
   assign mem_addr = illegal ? '0 : sel_addr;
   assign mem_wd   = sel_wd;

   assign cpu_gnt  = (win == WIN_CPU);
   assign dma_gnt  = (win == WIN_DMA);

   // A response due in the reset cycle is suppressed immediately, not one cycle later.
   assign cpu_rvalid = cpu_rvalid_q && !reset;
   assign dma_rvalid = dma_rvalid_q && !reset;
   assign cpu_rd     = cpu_rd_q;
   assign dma_rd     = dma_rd_q;
   assign err        = err_q;
   assign err_addr   = err_addr_q;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      if (reset) begin
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
         cpu_rd_q     <= '0;
         dma_rd_q     <= '0;
         err_q        <= 1'b0;
         err_addr_q   <= '0;
      end else begin
         cpu_rvalid_q <= (win == WIN_CPU) && !sel_we;
         dma_rvalid_q <= (win == WIN_DMA) && !sel_we;
         if ((win == WIN_CPU) && !sel_we) begin
            cpu_rd_q <= illegal ? '0 : mem_rd;
         end
         if ((win == WIN_DMA) && !sel_we) begin
            dma_rd_q <= illegal ? '0 : mem_rd;
         end
         if (illegal && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= sel_addr;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         last_dma <= 1'b1;
      end else if (win == WIN_CPU) begin
         last_dma <= 1'b0;
      end else if (win == WIN_DMA) begin
         last_dma <= 1'b1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         burst_cnt <= '0;
      end else if (!dma_req || (win == WIN_DMA)) begin
         burst_cnt <= '0;
      end else if ((win == WIN_CPU) && (burst_cnt != MAX_BURST_W)) begin
         burst_cnt <= burst_cnt + 4'd1;
      end
   end
`endif

endmodule
